// File: rtl/act_result_writer_pkg.sv
// Shared definitions for the activation result writer: default geometry
// (matching the activation stage) and the writer FSM state encoding.
package act_result_writer_pkg;

  localparam int MAT_MUL_SIZE = 4;
  localparam int DWIDTH       = 8;
  localparam int AWIDTH       = 10;
  localparam int MASK_WIDTH   = MAT_MUL_SIZE;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/act_result_writer_if.sv
// Bundle of job control, activation row stream and result BRAM write port.
// master = controller/activation side, slave = the writer.
interface act_result_writer_if
  import act_result_writer_pkg::*;
#(
  parameter int P_MAT_MUL_SIZE = MAT_MUL_SIZE,
  parameter int P_DWIDTH       = DWIDTH,
  parameter int P_AWIDTH       = AWIDTH,
  parameter int P_MASK_WIDTH   = MASK_WIDTH
);

  logic                                start;
  logic [P_AWIDTH-1:0]                 base_addr;
  logic [P_AWIDTH-1:0]                 address_stride;
  logic [P_AWIDTH-1:0]                 num_rows;
  logic                                in_data_available;
  logic [P_MAT_MUL_SIZE*P_DWIDTH-1:0]  inp_data;
  logic [P_MASK_WIDTH-1:0]             validity_mask;

  logic [P_AWIDTH-1:0]                 bram_addr;
  logic [P_MAT_MUL_SIZE*P_DWIDTH-1:0]  bram_wdata;
  logic [P_MASK_WIDTH-1:0]             bram_we;
  logic                                busy;
  logic                                done_write;
  logic                                overflow_err;

  modport master (
    output start, base_addr, address_stride, num_rows,
    output in_data_available, inp_data, validity_mask,
    input  bram_addr, bram_wdata, bram_we, busy, done_write, overflow_err
  );

  modport slave (
    input  start, base_addr, address_stride, num_rows,
    input  in_data_available, inp_data, validity_mask,
    output bram_addr, bram_wdata, bram_we, busy, done_write, overflow_err
  );

endinterface

// File: rtl/act_result_writer.sv
// Writes masked activation rows to the result BRAM at strided addresses,
// counts rows against the job length and flags rows arriving outside a job.
module act_result_writer
  import act_result_writer_pkg::*;
#(
  parameter int P_MAT_MUL_SIZE = MAT_MUL_SIZE,
  parameter int P_DWIDTH       = DWIDTH,
  parameter int P_AWIDTH       = AWIDTH,
  parameter int P_MASK_WIDTH   = MASK_WIDTH
) (
  input logic                clk,
  input logic                reset,
  act_result_writer_if.slave bus
);

  localparam int ROW_W = P_MAT_MUL_SIZE * P_DWIDTH;

  logic [1:0]              state_q,        state_d;
  logic [P_AWIDTH-1:0]     addr_q,         addr_d;
  logic [P_AWIDTH-1:0]     stride_q,       stride_d;
  logic [P_AWIDTH-1:0]     num_rows_q,     num_rows_d;
  logic [P_AWIDTH-1:0]     row_cnt_q,      row_cnt_d;
  logic [P_AWIDTH-1:0]     bram_addr_q,    bram_addr_d;
  logic [ROW_W-1:0]        bram_wdata_q,   bram_wdata_d;
  logic [P_MASK_WIDTH-1:0] bram_we_q,      bram_we_d;
  logic                    overflow_q,     overflow_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    num_rows_d   = num_rows_q;
    row_cnt_d    = row_cnt_q;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = '0;
    bram_we_d    = '0;
    overflow_d   = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_data_available) overflow_d = 1'b1;
        if (bus.start) begin
          addr_d     = bus.base_addr;
          stride_d   = bus.address_stride;
          num_rows_d = bus.num_rows;
          row_cnt_d  = '0;
          state_d    = (bus.num_rows == '0) ? ST_DONE : ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (bus.in_data_available) begin
          bram_addr_d = addr_q;
          bram_we_d   = bus.validity_mask;
          // Invalid lanes are written as zero so the data bus is clean under we=0.
          for (int i = 0; i < P_MAT_MUL_SIZE; i++) begin
            if (bus.validity_mask[i]) begin
              bram_wdata_d[i*P_DWIDTH +: P_DWIDTH] = bus.inp_data[i*P_DWIDTH +: P_DWIDTH];
            end
          end
          addr_d    = addr_q + stride_q;
          row_cnt_d = row_cnt_q + P_AWIDTH'(1);
          if (row_cnt_d == num_rows_q) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.in_data_available) overflow_d = 1'b1;
        if (!bus.start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      num_rows_q   <= '0;
      row_cnt_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_we_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      num_rows_q   <= num_rows_d;
      row_cnt_q    <= row_cnt_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      bram_we_q    <= bram_we_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.bram_addr    = bram_addr_q;
  assign bus.bram_wdata   = bram_wdata_q;
  assign bus.bram_we      = bram_we_q;
  assign bus.busy         = (state_q == ST_WRITE);
  assign bus.done_write   = (state_q == ST_DONE);
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_act_result_writer.sv
// Self-checking bench for act_result_writer: directed scenarios with literal
// expectations plus a randomized run checked against a job-level model.
module tb_act_result_writer;
  import act_result_writer_pkg::*;

  localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  act_result_writer_if bus ();

  act_result_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: a job is "open" with some rows left, or "finished"
  // until start drops; outputs describe what the previous edge wrote.
  bit                    m_open = 0;
  bit                    m_fin  = 0;
  int                    m_left = 0;
  logic [AWIDTH-1:0]     m_addr = '0;
  logic [AWIDTH-1:0]     m_stride = '0;
  logic [AWIDTH-1:0]     exp_addr = '0;
  logic [ROW_W-1:0]      exp_wdata = '0;
  logic [MASK_WIDTH-1:0] exp_we = '0;
  bit                    exp_ovf = 0;

  always @(posedge clk) begin
    exp_we    = '0;
    exp_wdata = '0;
    if (reset) begin
      m_open = 0; m_fin = 0; m_left = 0;
      exp_addr = '0; exp_ovf = 0;
    end else if (m_open) begin
      if (bus.in_data_available) begin
        exp_addr = m_addr;
        exp_we   = bus.validity_mask;
        for (int i = 0; i < MAT_MUL_SIZE; i++)
          if (bus.validity_mask[i])
            exp_wdata[i*DWIDTH +: DWIDTH] = bus.inp_data[i*DWIDTH +: DWIDTH];
        m_addr = m_addr + m_stride;
        m_left = m_left - 1;
        if (m_left == 0) begin m_open = 0; m_fin = 1; end
      end
    end else if (m_fin) begin
      if (bus.in_data_available) exp_ovf = 1;
      if (!bus.start) m_fin = 0;
    end else begin
      if (bus.in_data_available) exp_ovf = 1;
      if (bus.start) begin
        if (bus.num_rows == '0) m_fin = 1;
        else begin
          m_open   = 1;
          m_left   = int'(bus.num_rows);
          m_addr   = bus.base_addr;
          m_stride = bus.address_stride;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy",     64'(bus.busy),         64'(m_open));
    check("done",     64'(bus.done_write),   64'(m_fin));
    check("overflow", 64'(bus.overflow_err), 64'(exp_ovf));
    check("we",       64'(bus.bram_we),      64'(exp_we));
    check("wdata",    64'(bus.bram_wdata),   64'(exp_wdata));
    check("addr",     64'(bus.bram_addr),    64'(exp_addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup_job(input logic [AWIDTH-1:0] base, input logic [AWIDTH-1:0] stride,
                           input logic [AWIDTH-1:0] rows);
    bus.base_addr      = base;
    bus.address_stride = stride;
    bus.num_rows       = rows;
    bus.start          = 1'b1;
    tick();
    bus.start          = 1'b0;
  endtask

  logic [ROW_W-1:0] rows [4];

  initial begin
    rows[0] = 32'h0403_0201; rows[1] = 32'h0807_0605;
    rows[2] = 32'h0C0B_0A09; rows[3] = 32'h100F_0E0D;

    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.address_stride = '0; bus.num_rows = '0;
    bus.in_data_available = 1'b0; bus.inp_data = '0; bus.validity_mask = '0;
    repeat (2) tick();
    check("rst_addr", 64'(bus.bram_addr), 64'h0);
    check("rst_we",   64'(bus.bram_we),   64'h0);
    check("rst_busy", 64'(bus.busy),      64'h0);
    check("rst_done", 64'(bus.done_write), 64'h0);
    reset = 1'b0;
    tick();

    // Basic back-to-back job
    setup_job(10'h010, 10'd1, 10'd4);
    check("basic_busy", 64'(bus.busy), 64'h1);
    for (int k = 0; k < 4; k++) begin
      bus.in_data_available = 1'b1; bus.inp_data = rows[k]; bus.validity_mask = 4'hF;
      tick();
      check("basic_addr",  64'(bus.bram_addr),  64'(10'h010 + k));
      check("basic_we",    64'(bus.bram_we),    64'hF);
      check("basic_wdata", 64'(bus.bram_wdata), 64'(rows[k]));
    end
    check("basic_done", 64'(bus.done_write), 64'h1);
    check("basic_idle", 64'(bus.busy),       64'h0);
    bus.in_data_available = 1'b0;
    tick();
    check("basic_we_off", 64'(bus.bram_we), 64'h0);

    // Gapped rows with stride 4
    setup_job(10'h000, 10'd4, 10'd3);
    for (int k = 0; k < 3; k++) begin
      bus.in_data_available = 1'b1; bus.inp_data = ROW_W'($urandom); bus.validity_mask = 4'hF;
      tick();
      check("gap_addr", 64'(bus.bram_addr), 64'(4 * k));
      bus.in_data_available = 1'b0;
      if (k < 2) repeat (2) begin
        tick();
        check("gap_we_idle", 64'(bus.bram_we), 64'h0);
      end
    end
    check("gap_done", 64'(bus.done_write), 64'h1);
    tick();

    // Masked lanes, then a row landing in the DONE cycle
    setup_job(10'h020, 10'd1, 10'd1);
    bus.in_data_available = 1'b1; bus.inp_data = 32'hAABB_CCDD; bus.validity_mask = 4'b0101;
    tick();
    check("mask_we",    64'(bus.bram_we),    64'h5);
    check("mask_wdata", 64'(bus.bram_wdata), 64'h00BB_00DD);
    check("mask_done",  64'(bus.done_write), 64'h1);
    tick();
    check("done_row_ovf", 64'(bus.overflow_err), 64'h1);
    check("done_row_we",  64'(bus.bram_we),      64'h0);
    bus.in_data_available = 1'b0;
    reset = 1'b1; tick();
    check("ovf_cleared", 64'(bus.overflow_err), 64'h0);
    reset = 1'b0; tick();

    // Address wrap
    setup_job(10'h3FF, 10'd1, 10'd2);
    bus.in_data_available = 1'b1; bus.validity_mask = 4'hF;
    tick();
    check("wrap_addr0", 64'(bus.bram_addr), 64'h3FF);
    tick();
    check("wrap_addr1", 64'(bus.bram_addr), 64'h000);
    bus.in_data_available = 1'b0;
    tick();

    // Zero-row job with start held high
    bus.num_rows = '0; bus.start = 1'b1;
    tick();
    check("zero_done", 64'(bus.done_write), 64'h1);
    check("zero_we",   64'(bus.bram_we),    64'h0);
    tick();
    check("zero_hold", 64'(bus.done_write), 64'h1);
    bus.start = 1'b0;
    tick();
    check("zero_exit", 64'(bus.done_write), 64'h0);

    // Row while idle
    bus.in_data_available = 1'b1;
    tick();
    check("idle_ovf", 64'(bus.overflow_err), 64'h1);
    check("idle_we",  64'(bus.bram_we),      64'h0);
    bus.in_data_available = 1'b0;
    tick();
    check("ovf_sticky", 64'(bus.overflow_err), 64'h1);

    // Reset in the middle of a job
    reset = 1'b1; tick(); reset = 1'b0; tick();
    setup_job(10'h100, 10'd1, 10'd4);
    bus.in_data_available = 1'b1; bus.inp_data = 32'h1122_3344; bus.validity_mask = 4'hF;
    tick();
    check("mid_we", 64'(bus.bram_we), 64'hF);
    reset = 1'b1;
    tick();
    check("mid_rst_addr",  64'(bus.bram_addr),    64'h0);
    check("mid_rst_we",    64'(bus.bram_we),      64'h0);
    check("mid_rst_wdata", 64'(bus.bram_wdata),   64'h0);
    check("mid_rst_busy",  64'(bus.busy),         64'h0);
    check("mid_rst_ovf",   64'(bus.overflow_err), 64'h0);
    reset = 1'b0;
    tick();
    check("post_rst_ovf", 64'(bus.overflow_err), 64'h1);
    check("post_rst_we",  64'(bus.bram_we),      64'h0);
    bus.in_data_available = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset                 = ($urandom_range(0, 149) == 0);
      bus.start             = ($urandom_range(0, 3) == 0);
      bus.base_addr         = AWIDTH'($urandom);
      bus.address_stride    = AWIDTH'($urandom_range(0, 8) == 0 ? $urandom : $urandom_range(0, 5));
      bus.num_rows          = AWIDTH'($urandom_range(0, 6));
      bus.in_data_available = ($urandom_range(0, 2) != 0);
      bus.inp_data          = ROW_W'($urandom);
      bus.validity_mask     = MASK_WIDTH'($urandom);
      tick();
    end
    reset = 1'b0; bus.start = 1'b0; bus.in_data_available = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
